// File: rtl/des_pkg.sv
// DES constant tables, shift schedules, FSM state type and bit-wiring helpers.
// Bit order: vector index 0 is FIPS-46 bit 1. Table entries keep the
// 1-based FIPS numbering, so every permutation reads x[TABLE[i]-1].
package des_pkg;

  localparam int unsigned BLOCK_W = 64;
  localparam int unsigned HALF_W  = 32;
  localparam int unsigned CD_W    = 28;
  localparam int unsigned KEY56_W = 56;
  localparam int unsigned SUBK_W  = 48;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int unsigned FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  localparam int unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  // Row index = {b1,b6}, column = {b2..b5}; address = row*16 + col.
  localparam int unsigned SBOX [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
       0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
       4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
       3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
       0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
       1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{ 7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
       3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{ 2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
       4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
       9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
       4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{ 4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
       1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
       6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
       1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
       7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
       2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  // Decrypt rotates right (first round uses the unrotated key, i.e. K16).
  localparam int unsigned DEC_SHIFT [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  // Encrypt rotates left, the FIPS schedule.
  localparam int unsigned ENC_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(i)] = x[6'(IP_T[6'(i)] - 1)];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(i)] = x[6'(FP_T[6'(i)] - 1)];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[6'(i)] = x[6'(PC1_T[6'(i)] - 1)];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(i)] = x[6'(PC2_T[6'(i)] - 1)];
    return y;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(i)] = x[5'(E_T[6'(i)] - 1)];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[5'(i)] = x[5'(P_T[5'(i)] - 1)];
    return y;
  endfunction

  // FIPS left rotate: bit i takes bit i+s, i.e. a shift toward index 0.
  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] s);
    return (x >> s) | (x << (5'd28 - 5'(s)));
  endfunction

  // FIPS right rotate: bit i takes bit i-s.
  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] s);
    return (x << s) | (x >> (5'd28 - 5'(s)));
  endfunction

endpackage

// File: rtl/des_f.sv
// DES Feistel f-function: E-expansion, subkey XOR, eight S-boxes, P.
module des_f
  import des_pkg::*;
(
  input  logic [31:0] r,
  input  logic [47:0] k,
  output logic [31:0] result_c
);

  logic [47:0] x;
  logic [31:0] s;
  logic [5:0]  grp;
  logic [3:0]  v;

  // Expand, mix in subkey, substitute per 6-bit group, then permute.
  always_comb begin
    x   = e_expand(r) ^ k;
    s   = '0;
    grp = '0;
    v   = '0;
    for (int j = 0; j < 8; j++) begin
      grp = x[6'(6 * j) +: 6];
      v   = 4'(SBOX[3'(j)][{grp[0], grp[5], grp[1], grp[2], grp[3], grp[4]}]);
      s[5'(4 * j) +: 4] = {v[0], v[1], v[2], v[3]};
    end
    result_c = p_perm(s);
  end

endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption core, one Feistel round per clock.
// Optional macro DES_ENCRYPT_MODE_EN adds an 'enc' input selecting encryption.
module des_decrypt_core
  import des_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 16
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] in_key,
`ifdef DES_ENCRYPT_MODE_EN
  input  logic        enc,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data
);

  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NUM_ROUNDS - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       l;
  logic [31:0]       r;
  logic [27:0]       c;
  logic [27:0]       d;
  logic              enc_mode;
  logic [1:0]        shift;
  logic [27:0]       c_rot;
  logic [27:0]       d_rot;
  logic [47:0]       subkey;
  logic [31:0]       f_out;
  logic [63:0]       ip_in;
  logic [55:0]       pc1_key;

`ifdef DES_ENCRYPT_MODE_EN
  logic enc_q;
  assign enc_mode = enc_q;
`else
  assign enc_mode = 1'b0;
`endif

  assign ip_in   = ip_perm(in_data);
  assign pc1_key = pc1_perm(in_key);

  // Rotate C/D for the current round and derive its subkey.
  always_comb begin
    shift = 2'(DEC_SHIFT[cnt]);
    c_rot = rotr28(c, shift);
    d_rot = rotr28(d, shift);
    if (enc_mode) begin
      shift = 2'(ENC_SHIFT[cnt]);
      c_rot = rotl28(c, shift);
      d_rot = rotl28(d, shift);
    end
    subkey = pc2_perm({d_rot, c_rot});
  end

  des_f u_f (
    .r        (r),
    .k        (subkey),
    .result_c (f_out)
  );

  // Control FSM and datapath registers; output is captured on the last round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      cnt       <= '0;
      l         <= '0;
      r         <= '0;
      c         <= '0;
      d         <= '0;
`ifdef DES_ENCRYPT_MODE_EN
      enc_q     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            l        <= ip_in[31:0];
            r        <= ip_in[63:32];
            c        <= pc1_key[27:0];
            d        <= pc1_key[55:28];
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= S_ROUND;
`ifdef DES_ENCRYPT_MODE_EN
            enc_q    <= enc;
`endif
          end
        end
        S_ROUND: begin
          l <= r;
          r <= l ^ f_out;
          c <= c_rot;
          d <= d_rot;
          if (cnt == LAST_ROUND) begin
            // Pre-output is {R16, L16}: R16 occupies FIPS bits 1..32.
            out_data  <= fp_perm({r, l ^ f_out});
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
